// File: rtl/vip_avst_video_encoder.sv
// VIP Avalon-ST video encoder: frames pixel beats into control (type 0xF) and video (type 0x0) packets.
// Optional macro VIP_ENC_CTRL_REPEAT_EN: every video packet is preceded by a control packet.
module vip_avst_video_encoder #(
  parameter int          BITS_PER_SYMBOL    = 8,
  parameter int          SYMBOLS_PER_BEAT   = 3,
  parameter logic [15:0] WIDTH_DEFAULT      = 16'd640,
  parameter logic [15:0] HEIGHT_DEFAULT     = 16'd480,
  parameter logic [3:0]  INTERLACED_DEFAULT = 4'd0
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        din_valid,
  input  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] din_data,
  output logic                                        din_ready,
  input  logic                                        encoder_end_of_video,
  input  logic [15:0]                                 encoder_width,
  input  logic [15:0]                                 encoder_height,
  input  logic [3:0]                                  encoder_interlaced,
  input  logic                                        encoder_vip_ctrl_send,
  output logic                                        encoder_vip_ctrl_busy,
  input  logic                                        dout_ready,
  output logic                                        dout_valid,
  output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] dout_data,
  output logic                                        dout_startofpacket,
  output logic                                        dout_endofpacket
);

  localparam int DW         = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT;
  localparam int CTRL_BEATS = (9 + SYMBOLS_PER_BEAT - 1) / SYMBOLS_PER_BEAT;
  localparam int CW         = (CTRL_BEATS > 1) ? $clog2(CTRL_BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(CTRL_BEATS - 1);

  typedef enum logic [2:0] {
    IDLE,
    CTRL_HDR,
    CTRL_DATA,
    VID_HDR,
    VID_DATA
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   beatCnt_q, beatCnt_d;
  logic [15:0]     width_q, width_d;
  logic [15:0]     height_q, height_d;
  logic [3:0]      interlaced_q, interlaced_d;
  logic            doutValid_q, doutValid_d;
  logic [DW-1:0]   doutData_q, doutData_d;
  logic            doutSop_q, doutSop_d;
  logic            doutEop_q, doutEop_d;
  logic            adv;
  logic [DW-1:0]   ctrlBeat;

  function automatic logic [3:0] ctrlNibble(input logic [15:0] w, input logic [15:0] h,
                                            input logic [3:0] il, input int k);
    case (k)
      0:       ctrlNibble = w[15:12];
      1:       ctrlNibble = w[11:8];
      2:       ctrlNibble = w[7:4];
      3:       ctrlNibble = w[3:0];
      4:       ctrlNibble = h[15:12];
      5:       ctrlNibble = h[11:8];
      6:       ctrlNibble = h[7:4];
      7:       ctrlNibble = h[3:0];
      8:       ctrlNibble = il;
      default: ctrlNibble = 4'h0;
    endcase
  endfunction

  // The output register may take a new beat whenever it is empty or being drained.
  assign adv = ~doutValid_q | dout_ready;
  assign din_ready = (state_q == VID_DATA) && adv;
  assign encoder_vip_ctrl_busy = (state_q != IDLE);

  always_comb begin
    ctrlBeat = '0;
    for (int s = 0; s < SYMBOLS_PER_BEAT; s++) begin
      ctrlBeat[s*BITS_PER_SYMBOL +: 4] =
        ctrlNibble(width_q, height_q, interlaced_q, int'(beatCnt_q) * SYMBOLS_PER_BEAT + s);
    end
  end

  always_comb begin
    state_d      = state_q;
    beatCnt_d    = beatCnt_q;
    width_d      = width_q;
    height_d     = height_q;
    interlaced_d = interlaced_q;
    doutValid_d  = doutValid_q;
    doutData_d   = doutData_q;
    doutSop_d    = doutSop_q;
    doutEop_d    = doutEop_q;
    if (adv) begin
      // A drained register stays empty unless this state loads a beat.
      doutValid_d = 1'b0;
      doutSop_d   = 1'b0;
      doutEop_d   = 1'b0;
      case (state_q)
        IDLE: begin
          if (encoder_vip_ctrl_send) begin
            width_d      = encoder_width;
            height_d     = encoder_height;
            interlaced_d = encoder_interlaced;
            state_d      = CTRL_HDR;
          end else if (din_valid) begin
`ifdef VIP_ENC_CTRL_REPEAT_EN
            state_d = CTRL_HDR;
`else
            state_d = VID_HDR;
`endif
          end
        end
        CTRL_HDR: begin
          doutValid_d = 1'b1;
          doutData_d  = {{(DW-4){1'b0}}, 4'hF};
          doutSop_d   = 1'b1;
          beatCnt_d   = '0;
          state_d     = CTRL_DATA;
        end
        CTRL_DATA: begin
          doutValid_d = 1'b1;
          doutData_d  = ctrlBeat;
          if (beatCnt_q == LAST_BEAT) begin
            doutEop_d = 1'b1;
            beatCnt_d = '0;
`ifdef VIP_ENC_CTRL_REPEAT_EN
            state_d   = din_valid ? VID_HDR : IDLE;
`else
            state_d   = IDLE;
`endif
          end else begin
            beatCnt_d = beatCnt_q + CW'(1);
          end
        end
        VID_HDR: begin
          doutValid_d = 1'b1;
          doutData_d  = '0;
          doutSop_d   = 1'b1;
          state_d     = VID_DATA;
        end
        VID_DATA: begin
          if (din_valid) begin
            doutValid_d = 1'b1;
            doutData_d  = din_data;
            doutEop_d   = encoder_end_of_video;
            if (encoder_end_of_video) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      beatCnt_q    <= '0;
      width_q      <= WIDTH_DEFAULT;
      height_q     <= HEIGHT_DEFAULT;
      interlaced_q <= INTERLACED_DEFAULT;
      doutValid_q  <= 1'b0;
      doutData_q   <= '0;
      doutSop_q    <= 1'b0;
      doutEop_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      beatCnt_q    <= beatCnt_d;
      width_q      <= width_d;
      height_q     <= height_d;
      interlaced_q <= interlaced_d;
      doutValid_q  <= doutValid_d;
      doutData_q   <= doutData_d;
      doutSop_q    <= doutSop_d;
      doutEop_q    <= doutEop_d;
    end
  end

  assign dout_valid         = doutValid_q;
  assign dout_data          = doutData_q;
  assign dout_startofpacket = doutSop_q;
  assign dout_endofpacket   = doutEop_q;

endmodule

// File: tb/tb_vip_avst_video_encoder.sv
// Testbench for vip_avst_video_encoder: directed and randomized packets checked against a packet-level model.
module tb_vip_avst_video_encoder;

  localparam int BPS = 8;
  localparam int SPB = 3;
  localparam int DW  = BPS * SPB;

  logic          clk;
  logic          rst;
  logic          din_valid;
  logic [DW-1:0] din_data;
  logic          din_ready;
  logic          encoder_end_of_video;
  logic [15:0]   encoder_width;
  logic [15:0]   encoder_height;
  logic [3:0]    encoder_interlaced;
  logic          encoder_vip_ctrl_send;
  logic          encoder_vip_ctrl_busy;
  logic          dout_ready;
  logic          dout_valid;
  logic [DW-1:0] dout_data;
  logic          dout_startofpacket;
  logic          dout_endofpacket;

  typedef struct {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
  } beat_t;

  beat_t         expQ[$];
  beat_t         monBeat;
  int            compared   = 0;
  int            mismatched = 0;
  int            holdLow    = 0;
  bit            randReady  = 0;
  bit            prevStall  = 0;
  logic [DW-1:0] prevData;
  logic          prevSop;
  logic          prevEop;
  logic [15:0]   lastW = 16'd640;
  logic [15:0]   lastH = 16'd480;
  logic [3:0]    lastI = 4'd0;

  vip_avst_video_encoder #(
    .BITS_PER_SYMBOL (BPS),
    .SYMBOLS_PER_BEAT(SPB)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .din_valid            (din_valid),
    .din_data             (din_data),
    .din_ready            (din_ready),
    .encoder_end_of_video (encoder_end_of_video),
    .encoder_width        (encoder_width),
    .encoder_height       (encoder_height),
    .encoder_interlaced   (encoder_interlaced),
    .encoder_vip_ctrl_send(encoder_vip_ctrl_send),
    .encoder_vip_ctrl_busy(encoder_vip_ctrl_busy),
    .dout_ready           (dout_ready),
    .dout_valid           (dout_valid),
    .dout_data            (dout_data),
    .dout_startofpacket   (dout_startofpacket),
    .dout_endofpacket     (dout_endofpacket)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Control packet model: header 0xF, then nine nibbles packed SPB per beat into symbol LSBs.
  task automatic expectCtrl(input logic [15:0] w, input logic [15:0] h, input logic [3:0] il);
    int            nib[9];
    int            nBeats;
    int            k;
    logic [DW-1:0] d;
    for (int j = 0; j < 4; j++) begin
      nib[j]     = int'((w >> (12 - 4*j)) & 16'hF);
      nib[4 + j] = int'((h >> (12 - 4*j)) & 16'hF);
    end
    nib[8] = int'(il);
    expQ.push_back('{data: DW'(4'hF), sop: 1'b1, eop: 1'b0});
    nBeats = (9 + SPB - 1) / SPB;
    for (int b = 0; b < nBeats; b++) begin
      d = '0;
      for (int s = 0; s < SPB; s++) begin
        k = b * SPB + s;
        if (k < 9) d = d | (DW'(nib[k]) << (s * BPS));
      end
      expQ.push_back('{data: d, sop: 1'b0, eop: (b == nBeats - 1)});
    end
    lastW = w;
    lastH = h;
    lastI = il;
  endtask

  task automatic applyStimulus(input logic [DW-1:0] d, input logic eov);
    bit done = 0;
    din_valid            = 1'b1;
    din_data             = d;
    encoder_end_of_video = eov;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (din_ready) done = 1;
      @(posedge clk);
      #1;
    end
    checkOutput("din_accept_timeout", 32'(done), 32'd1);
    din_valid            = 1'b0;
    din_data             = DW'($urandom);
    encoder_end_of_video = 1'($urandom_range(0, 1));
  endtask

  // Raises send with the given fields and returns #1 after the edge that accepted it.
  task automatic sendCtrl(input logic [15:0] w, input logic [15:0] h, input logic [3:0] il);
    bit done = 0;
    encoder_width         = w;
    encoder_height        = h;
    encoder_interlaced    = il;
    encoder_vip_ctrl_send = 1'b1;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (!encoder_vip_ctrl_busy && (!dout_valid || dout_ready)) done = 1;
      @(posedge clk);
      #1;
    end
    checkOutput("send_accept_timeout", 32'(done), 32'd1);
    encoder_vip_ctrl_send = 1'b0;
    checkOutput("busy_after_send", 32'(encoder_vip_ctrl_busy), 32'd1);
    encoder_width      = 16'($urandom);
    encoder_height     = 16'($urandom);
    encoder_interlaced = 4'($urandom);
  endtask

  task automatic sendVideo(input int n, input int stallAt, input bit fixedPat,
                           input bit afterSend, input logic [DW-1:0] first);
    logic [DW-1:0] d;
    bit            last;
`ifdef VIP_ENC_CTRL_REPEAT_EN
    if (!afterSend) expectCtrl(lastW, lastH, lastI);
`endif
    expQ.push_back('{data: '0, sop: 1'b1, eop: 1'b0});
    for (int i = 0; i < n; i++) begin
      if (fixedPat) d = DW'(24'h112233 + i * 24'h111111);
      else if (i == 0 && afterSend) d = first;
      else d = DW'($urandom);
      last = (i == n - 1);
      expQ.push_back('{data: d, sop: 1'b0, eop: last});
      if (i == stallAt) begin
        @(negedge clk);
        holdLow = 3;
        @(posedge clk);
        #1;
      end
      applyStimulus(d, last);
    end
  endtask

  // Sink backpressure: forced-low windows, random stalls, or always ready.
  initial begin
    dout_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (holdLow > 0) begin
        dout_ready = 1'b0;
        holdLow--;
      end else if (randReady) begin
        dout_ready = ($urandom_range(0, 3) != 0);
      end else begin
        dout_ready = 1'b1;
      end
    end
  end

  // Output monitor: scoreboard on each transfer, hold checks across stalls.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prevStall = 0;
      end else begin
        if (prevStall) begin
          checkOutput("hold_valid", 32'(dout_valid), 32'd1);
          checkOutput("hold_data", 32'(dout_data), 32'(prevData));
          checkOutput("hold_sop", 32'(dout_startofpacket), 32'(prevSop));
          checkOutput("hold_eop", 32'(dout_endofpacket), 32'(prevEop));
        end
        if (dout_valid && !dout_ready) checkOutput("stall_din_ready", 32'(din_ready), 32'd0);
        if (dout_valid && dout_ready) begin
          checkOutput("beat_expected", 32'(expQ.size() != 0), 32'd1);
          if (expQ.size() != 0) begin
            monBeat = expQ.pop_front();
            checkOutput("beat_data", 32'(dout_data), 32'(monBeat.data));
            checkOutput("beat_sop", 32'(dout_startofpacket), 32'(monBeat.sop));
            checkOutput("beat_eop", 32'(dout_endofpacket), 32'(monBeat.eop));
          end
        end
        prevStall = dout_valid && !dout_ready;
        prevData  = dout_data;
        prevSop   = dout_startofpacket;
        prevEop   = dout_endofpacket;
      end
    end
  end

  initial begin
    int          n;
    bit          drained;
    logic [15:0] w;
    logic [15:0] h;
    logic [3:0]  il;
    logic [DW-1:0] d;

    rst                   = 1'b1;
    din_valid             = 1'b0;
    din_data              = '0;
    encoder_end_of_video  = 1'b0;
    encoder_width         = '0;
    encoder_height        = '0;
    encoder_interlaced    = '0;
    encoder_vip_ctrl_send = 1'b0;
    #1;
    checkOutput("reset_valid", 32'(dout_valid), 32'd0);
    checkOutput("reset_data", 32'(dout_data), 32'd0);
    checkOutput("reset_sop", 32'(dout_startofpacket), 32'd0);
    checkOutput("reset_eop", 32'(dout_endofpacket), 32'd0);
    checkOutput("reset_din_ready", 32'(din_ready), 32'd0);
    checkOutput("reset_busy", 32'(encoder_vip_ctrl_busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] control packet 640x480 progressive");
    expQ.push_back('{data: 24'h00000F, sop: 1'b1, eop: 1'b0});
    expQ.push_back('{data: 24'h080200, sop: 1'b0, eop: 1'b0});
    expQ.push_back('{data: 24'h010000, sop: 1'b0, eop: 1'b0});
    expQ.push_back('{data: 24'h00000E, sop: 1'b0, eop: 1'b1});
    lastW = 16'd640; lastH = 16'd480; lastI = 4'd0;
    sendCtrl(16'd640, 16'd480, 4'd0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!encoder_vip_ctrl_busy) break;
      n++;
    end
    checkOutput("busy_cycles", 32'(n), 32'd4);
    checkOutput("eop_at_busy_fall", 32'(dout_endofpacket && dout_valid), 32'd1);
    @(posedge clk);
    #1;

    $display("[TB] four-pixel video packet");
    sendVideo(4, -1, 1'b1, 1'b0, '0);

    $display("[TB] video packet with sink stall");
    sendVideo(6, 3, 1'b0, 1'b0, '0);

    $display("[TB] send and pixel in the same cycle");
    w = 16'($urandom); h = 16'($urandom); il = 4'($urandom);
    d = DW'($urandom);
    din_valid            = 1'b1;
    din_data             = d;
    encoder_end_of_video = 1'b0;
    expectCtrl(w, h, il);
    sendCtrl(w, h, il);
    sendVideo(3, -1, 1'b0, 1'b1, d);

    $display("[TB] randomized traffic with random backpressure");
    randReady = 1;
    for (int r = 0; r < 14; r++) begin
      case ($urandom_range(0, 2))
        0: begin
          w = 16'($urandom); h = 16'($urandom); il = 4'($urandom);
          expectCtrl(w, h, il);
          sendCtrl(w, h, il);
        end
        1: sendVideo(int'($urandom_range(1, 6)), -1, 1'b0, 1'b0, '0);
        default: begin
          w = 16'($urandom); h = 16'($urandom); il = 4'($urandom);
          d = DW'($urandom);
          din_valid            = 1'b1;
          din_data             = d;
          encoder_end_of_video = 1'b0;
          expectCtrl(w, h, il);
          sendCtrl(w, h, il);
          sendVideo(int'($urandom_range(1, 5)), -1, 1'b0, 1'b1, d);
        end
      endcase
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    randReady = 0;

    $display("[TB] reset in the middle of a video packet");
    sendVideoPartial();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_valid", 32'(dout_valid), 32'd0);
    checkOutput("midrst_data", 32'(dout_data), 32'd0);
    checkOutput("midrst_sop", 32'(dout_startofpacket), 32'd0);
    checkOutput("midrst_eop", 32'(dout_endofpacket), 32'd0);
    checkOutput("midrst_din_ready", 32'(din_ready), 32'd0);
    checkOutput("midrst_busy", 32'(encoder_vip_ctrl_busy), 32'd0);
    expQ.delete();
    din_valid = 1'b0;
    lastW = 16'd640; lastH = 16'd480; lastI = 4'd0;
    w = 16'($urandom); h = 16'($urandom); il = 4'($urandom);
    encoder_width         = w;
    encoder_height        = h;
    encoder_interlaced    = il;
    encoder_vip_ctrl_send = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("send_after_release", 32'(encoder_vip_ctrl_busy), 32'd1);
    encoder_vip_ctrl_send = 1'b0;
    expectCtrl(w, h, il);
    sendVideo(2, -1, 1'b0, 1'b0, '0);

    drained = 0;
    for (int i = 0; i < 500 && !drained; i++) begin
      @(posedge clk);
      #1;
      if (expQ.size() == 0) drained = 1;
    end
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("final_valid", 32'(dout_valid), 32'd0);
    checkOutput("final_busy", 32'(encoder_vip_ctrl_busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Starts a video packet that is never ended: two accepted pixels, a third left pending.
  task automatic sendVideoPartial();
    logic [DW-1:0] d;
`ifdef VIP_ENC_CTRL_REPEAT_EN
    expectCtrl(lastW, lastH, lastI);
`endif
    expQ.push_back('{data: '0, sop: 1'b1, eop: 1'b0});
    for (int i = 0; i < 2; i++) begin
      d = DW'($urandom);
      expQ.push_back('{data: d, sop: 1'b0, eop: 1'b0});
      applyStimulus(d, 1'b0);
    end
    din_valid            = 1'b1;
    din_data             = DW'($urandom);
    encoder_end_of_video = 1'b0;
  endtask

endmodule

// File: doc/vip_avst_video_encoder.md
Name: vip_avst_video_encoder

Overview:
- Sits directly downstream of the flow-control output stage and drives the VIP Avalon-ST video output.
- Accepts pixel beats (ready/valid) and control-packet requests (width/height/interlaced plus send/busy).
- Emits framed packets: control packets (type 0xF) and video packets (type 0x0), with startofpacket/endofpacket.
- Output is registered; it holds data under backpressure and never drops or duplicates a beat.

Parameters:
BITS_PER_SYMBOL, 8, bits per symbol (must be >=4)
SYMBOLS_PER_BEAT, 3, symbols per beat; symbol 0 occupies the LSBs
WIDTH_DEFAULT, 16'd640, width used by control repeat before any control packet has been captured
HEIGHT_DEFAULT, 16'd480, height used by control repeat before any capture
INTERLACED_DEFAULT, 4'd0, interlace nibble used by control repeat before any capture

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
din_valid  in  1  pixel beat valid
din_data  in  BPS*SPB  pixel beat
din_ready  out  1  beat accepted when din_valid&din_ready
encoder_end_of_video  in  1  qualifies the accepted beat as the last of the frame
encoder_width  in  16  control packet width
encoder_height  in  16  control packet height
encoder_interlaced  in  4  control packet interlace nibble
encoder_vip_ctrl_send  in  1  request a control packet
encoder_vip_ctrl_busy  out  1  encoder not accepting a send
dout_ready  in  1  sink ready (ready latency 0)
dout_valid  out  1  output beat valid
dout_data  out  BPS*SPB  output beat
dout_startofpacket  out  1  first beat of packet
dout_endofpacket  out  1  last beat of packet

Behaviour:
- Reset: dout_valid, dout_startofpacket, dout_endofpacket, dout_data = 0. din_ready = 0. State = IDLE, so busy = 0. Captured control fields load the *_DEFAULT values.
- Output register advances when ~dout_valid | dout_ready ("adv"). While dout_valid=1 and dout_ready=0, data, sop and eop are held stable.
- encoder_vip_ctrl_busy = (state != IDLE), combinational from state.
- States and transitions:
  - IDLE: on adv, if send: capture width/height/interlaced and go to CTRL_HDR. Else if din_valid: go to VID_HDR. If both are high in the same cycle, send wins.
  - CTRL_HDR: on adv, load beat with symbol0 = 4'hF and all other bits 0, sop=1. Go to CTRL_DATA.
  - CTRL_DATA: CTRL_BEATS = ceil(9/SPB) beats.
    - Nibble sequence k=0..8: w[15:12], w[11:8], w[7:4], w[3:0], h[15:12], h[11:8], h[7:4], h[3:0], interlaced.
    - Nibble k goes to beat k/SPB, symbol k%SPB, in bits [3:0] of that symbol. Upper symbol bits and unused trailing symbols are 0.
    - Beat counter increments on adv. eop=1 on the last beat. Return to IDLE after it is loaded.
  - VID_HDR: on adv, load beat with all bits 0 and sop=1. Go to VID_DATA.
  - VID_DATA: din_ready = adv. Each accepted beat is copied to dout_data. eop = encoder_end_of_video of that beat. After loading the eop beat, go to IDLE.
- In IDLE, CTRL_* and VID_HDR, din_ready = 0.
- encoder_end_of_video is ignored when din_valid=0.
- A video packet always contains >=1 data beat.
- Latency: a state's beat appears on dout one cycle after the adv that loads it.
- A send while busy is ignored; the upstream stage holds it pending.
- Reset mid-packet: outputs clear immediately and no eop is emitted for the truncated packet.

Optional Feature:
- Macro VIP_ENC_CTRL_REPEAT_EN defined: in IDLE with din_valid=1 and no send, go to CTRL_HDR using the last captured fields (the defaults after reset). On leaving CTRL_DATA, go to VID_HDR instead of IDLE. Every video packet is therefore preceded by a control packet. An explicit send still takes priority and is itself followed by VID_HDR only if din_valid=1.
- Macro not defined: control packets are sent only on encoder_vip_ctrl_send.

Test Plan:
1. Assert rst mid-run, then release -> all outputs 0, busy 0. First send is accepted the cycle after release.
2. BPS=8, SPB=3, dout_ready=1, send with w=640, h=480, i=0 -> beats 0x00000F (sop), 0x080200, 0x010000, 0x00000E (eop). Busy is high from the cycle after send until eop is loaded.
3. 4 pixels 0x112233..0x445566, end_of_video on the 4th -> 0x000000 (sop), then the 4 pixels in order with eop on 0x445566. No control packet unless the macro is defined.
4. dout_ready low for 3 cycles mid-video -> dout_data, sop and eop stable; din_ready=0; no beat lost or duplicated.
5. Send and din_valid high in the same IDLE cycle -> full control packet first, then video header, then pixels.
6. VIP_ENC_CTRL_REPEAT_EN defined, no prior send, din_valid=1 -> control packet carrying 640x480/0, then video packet.
